guess_engine: RTL and testbench

Parametrised codebreaker controller for the mastermind game. It collects a guess of `CODE_LEN` symbols from the selected breaker (A or B) and scores it against the codemaker's secret. Each attempt produces exact-position and wrong-position match counts. It tracks lives, awards the round point, and requests the role swap. It sits between the switch/enter-button front end and the LED feedback, score and active-player logic.

---
 rtl/guess_engine_if.sv | 45 ++++
 rtl/guess_engine.sv | 154 +++++++++++++++
 tb/tb_guess_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_engine_if.sv
// Front-end inputs and feedback/score outputs of the mastermind codebreaker controller.
// slave is the engine side; master is the switch/button front end and display logic.
interface guess_engine_if #(
  parameter int SYM_W    = 3,
  parameter int CODE_LEN = 4,
  parameter int PTS_W    = 2,
  parameter int RND_W    = 2
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic                      start;
  logic                      breaker_b;
  logic [SYM_W-1:0]          SW;
  logic                      enterA;
  logic                      enterB;
  logic [CODE_LEN*SYM_W-1:0] secret;
  logic [PTS_W-1:0]          init_ptA;
  logic [PTS_W-1:0]          init_ptB;
  logic [RND_W-1:0]          round_in;

  logic [CODE_LEN*SYM_W-1:0] guess;
  logic [CNT_W-1:0]          exact_cnt;
  logic [CNT_W-1:0]          partial_cnt;
  logic                      fb_valid;
  logic [2:0]                lives_left;
  logic [PTS_W-1:0]          pointsOfA;
  logic [PTS_W-1:0]          pointsOfB;
  logic [RND_W-1:0]          round_out;
  logic                      busy;
  logic                      round_done;
  logic                      swap_req;
  logic                      swap_to_b;

  modport master (
    output start, breaker_b, SW, enterA, enterB, secret, init_ptA, init_ptB, round_in,
    input  guess, exact_cnt, partial_cnt, fb_valid, lives_left, pointsOfA, pointsOfB,
           round_out, busy, round_done, swap_req, swap_to_b
  );

  modport slave (
    input  start, breaker_b, SW, enterA, enterB, secret, init_ptA, init_ptB, round_in,
    output guess, exact_cnt, partial_cnt, fb_valid, lives_left, pointsOfA, pointsOfB,
           round_out, busy, round_done, swap_req, swap_to_b
  );
endinterface

// File: rtl/guess_engine.sv
// Mastermind codebreaker round controller: collects a guess, scores it, tracks lives and points.
// Last accepted enter -> SCORE next cycle; counts valid from the following cycle; display states last HOLD cycles.
module guess_engine #(
  parameter int SYM_W    = 3,
  parameter int CODE_LEN = 4,
  parameter int LIVES    = 3,
  parameter int HOLD     = 4,
  parameter int PTS_W    = 2,
  parameter int RND_W    = 2
) (
  input  logic          clk,
  input  logic          reset,
  guess_engine_if.slave bus
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TMR_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int NSYM  = 1 << SYM_W;

  typedef enum logic [2:0] {IDLE, SHOW_LIVES, ENTRY, SCORE, FEEDBACK, WIN, LOSE} state_t;

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    timer;
  logic [CNT_W-1:0]    sym_cnt;
  logic                breaker;
  logic                hold_done;
  logic                accept;
  logic [CODE_LEN-1:0] pos_match;
  logic [CNT_W-1:0]    exact_nxt, partial_nxt;
  logic [CNT_W-1:0]    sec_n, gue_n;

  function automatic logic [PTS_W-1:0] sat_inc(input logic [PTS_W-1:0] p);
    return (&p) ? p : p + 1'b1;
  endfunction

  assign hold_done = (timer == TMR_W'(HOLD - 1));
  assign accept    = (breaker ? bus.enterB : bus.enterA) && (bus.SW != '0);

  // Timer restarts whenever the state changes, so every hold state lasts exactly HOLD cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : timer + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.start) state_nxt = SHOW_LIVES;
      SHOW_LIVES: if (hold_done) state_nxt = ENTRY;
      ENTRY:      if (accept && sym_cnt == CNT_W'(CODE_LEN - 1)) state_nxt = SCORE;
      SCORE:      state_nxt = (exact_nxt == CNT_W'(CODE_LEN)) ? WIN : FEEDBACK;
      FEEDBACK:   if (hold_done) state_nxt = (bus.lives_left == '0) ? LOSE : SHOW_LIVES;
      WIN, LOSE:  if (hold_done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Symbol value 0 is excluded from the partial count, so blank secret positions never score.
  always_comb begin
    pos_match   = '0;
    exact_nxt   = '0;
    partial_nxt = '0;
    sec_n       = '0;
    gue_n       = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (bus.guess[i*SYM_W +: SYM_W] == bus.secret[i*SYM_W +: SYM_W]) begin
        pos_match[i] = 1'b1;
        exact_nxt    = exact_nxt + CNT_W'(1);
      end
    end
    for (int v = 1; v < NSYM; v++) begin
      sec_n = '0;
      gue_n = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
        if (!pos_match[i]) begin
          if (bus.secret[i*SYM_W +: SYM_W] == SYM_W'(v)) sec_n = sec_n + CNT_W'(1);
          if (bus.guess[i*SYM_W +: SYM_W]  == SYM_W'(v)) gue_n = gue_n + CNT_W'(1);
        end
      end
      partial_nxt = partial_nxt + ((sec_n < gue_n) ? sec_n : gue_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.guess       <= '0;
      bus.exact_cnt   <= '0;
      bus.partial_cnt <= '0;
      bus.lives_left  <= '0;
      bus.pointsOfA   <= '0;
      bus.pointsOfB   <= '0;
      bus.round_out   <= '0;
      sym_cnt         <= '0;
      breaker         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.lives_left  <= 3'(LIVES);
          bus.pointsOfA   <= bus.init_ptA;
          bus.pointsOfB   <= bus.init_ptB;
          bus.round_out   <= bus.round_in;
          bus.guess       <= '0;
          bus.exact_cnt   <= '0;
          bus.partial_cnt <= '0;
          sym_cnt         <= '0;
          if (bus.start) breaker <= bus.breaker_b;
        end
        SHOW_LIVES: begin
          if (hold_done) begin
            bus.guess <= '0;
            sym_cnt   <= '0;
          end
        end
        ENTRY: begin
          if (accept) begin
            bus.guess <= {bus.guess[(CODE_LEN-1)*SYM_W-1:0], bus.SW};
            sym_cnt   <= sym_cnt + CNT_W'(1);
          end
        end
        SCORE: begin
          bus.exact_cnt   <= exact_nxt;
          bus.partial_cnt <= partial_nxt;
          if (exact_nxt != CNT_W'(CODE_LEN) && bus.lives_left != '0)
            bus.lives_left <= bus.lives_left - 3'd1;
        end
        WIN: begin
          if (timer == '0) begin
            if (breaker) bus.pointsOfB <= sat_inc(bus.pointsOfB);
            else         bus.pointsOfA <= sat_inc(bus.pointsOfA);
            bus.round_out <= bus.round_out + 1'b1;
          end
        end
        LOSE: begin
          if (timer == '0) begin
            if (breaker) bus.pointsOfA <= sat_inc(bus.pointsOfA);
            else         bus.pointsOfB <= sat_inc(bus.pointsOfB);
            bus.round_out <= bus.round_out + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.fb_valid   = (state == FEEDBACK) || (state == WIN);
  assign bus.swap_req   = (state == WIN) || (state == LOSE);
  assign bus.swap_to_b  = bus.swap_req && breaker;
  assign bus.round_done = bus.swap_req && hold_done;
endmodule

// File: tb/tb_guess_engine.sv
// Scoreboard bench for guess_engine: score and round-end expectations are queued at stimulus time
// and checked when fb_valid rises or round_done pulses.
module tb_guess_engine;
  localparam int SYM_W = 3, CODE_LEN = 4, LIVES = 3, HOLD = 4, PTS_W = 2, RND_W = 2;

  typedef struct { int exact; int partial; int lives; } score_t;
  typedef struct { int pta; int ptb; int rnd; int swb; } round_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  guess_engine_if #(.SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .PTS_W(PTS_W), .RND_W(RND_W)) bus();

  guess_engine #(.SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .LIVES(LIVES), .HOLD(HOLD),
                 .PTS_W(PTS_W), .RND_W(RND_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  score_t score_q[$];
  round_t round_q[$];
  score_t se;
  round_t re;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     rd_count = 0;
  int     fb_len   = 0;
  logic   fb_prev  = 1'b0;
  int     exp_lives;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] code4(input int a, input int b, input int c, input int d);
    return {3'(a), 3'(b), 3'(c), 3'(d)};
  endfunction

  // Total common symbols minus exact hits gives the wrong-position count.
  function automatic void model(input logic [11:0] g, input logic [11:0] s,
                                output int ex, output int pa);
    int tot = 0;
    ex = 0;
    for (int i = 0; i < CODE_LEN; i++)
      if (g[i*SYM_W +: SYM_W] == s[i*SYM_W +: SYM_W]) ex++;
    for (int v = 1; v < 8; v++) begin
      int cs = 0, cg = 0;
      for (int i = 0; i < CODE_LEN; i++) begin
        if (int'(s[i*SYM_W +: SYM_W]) == v) cs++;
        if (int'(g[i*SYM_W +: SYM_W]) == v) cg++;
      end
      tot += (cs < cg) ? cs : cg;
    end
    pa = tot - ex;
  endfunction

  always @(negedge clk) begin
    if (bus.fb_valid && !fb_prev) begin
      check("score_q_avail", score_q.size() != 0, 1);
      if (score_q.size() != 0) begin
        se = score_q.pop_front();
        check("exact_cnt", bus.exact_cnt, se.exact);
        check("partial_cnt", bus.partial_cnt, se.partial);
        check("lives_left", bus.lives_left, se.lives);
      end
    end
    if (bus.fb_valid) fb_len++;
    else if (fb_prev) begin
      check("fb_hold_len", fb_len, HOLD);
      fb_len = 0;
    end
    fb_prev = bus.fb_valid;
    if (bus.round_done) begin
      rd_count++;
      check("round_q_avail", round_q.size() != 0, 1);
      if (round_q.size() != 0) begin
        re = round_q.pop_front();
        check("pointsOfA", bus.pointsOfA, re.pta);
        check("pointsOfB", bus.pointsOfB, re.ptb);
        check("round_out", bus.round_out, re.rnd);
        check("swap_to_b", bus.swap_to_b, re.swb);
        check("swap_req", bus.swap_req, 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 500) begin
      tick(1);
      k++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  task automatic start_round(input logic b, input logic [11:0] sec, input int pa, input int pb,
                             input int rnd);
    wait_idle();
    bus.breaker_b = b;
    bus.secret    = sec;
    bus.init_ptA  = PTS_W'(pa);
    bus.init_ptB  = PTS_W'(pb);
    bus.round_in  = RND_W'(rnd);
    exp_lives     = LIVES;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    tick(HOLD + 1);
  endtask

  task automatic press(input logic a, input logic b, input int sym);
    @(negedge clk);
    bus.SW     = SYM_W'(sym);
    bus.enterA = a;
    bus.enterB = b;
    @(negedge clk);
    bus.SW     = '0;
    bus.enterA = 1'b0;
    bus.enterB = 1'b0;
  endtask

  task automatic play_guess(input logic b, input logic [11:0] g, input logic [11:0] sec,
                            input int first);
    int ex, pa, k;
    score_t s;
    model(g, sec, ex, pa);
    if (ex != CODE_LEN && exp_lives > 0) exp_lives--;
    s.exact = ex; s.partial = pa; s.lives = exp_lives;
    score_q.push_back(s);
    for (int i = first; i < CODE_LEN; i++)
      press(!b, b, int'(g[(CODE_LEN-1-i)*SYM_W +: SYM_W]));
    check("guess_reg", bus.guess, g);
    check("score_cycle_fb", bus.fb_valid, 0);
    tick(1);
    check("fb_first_cycle", bus.fb_valid, 1);
    k = 0;
    while (bus.fb_valid && k < 100) begin
      tick(1);
      k++;
    end
    check("fb_timeout", bus.fb_valid, 0);
    if (ex != CODE_LEN && exp_lives != 0) tick(HOLD + 1);
  endtask

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.breaker_b = 1'b0;
    bus.SW        = '0;
    bus.enterA    = 1'b0;
    bus.enterB    = 1'b0;
    bus.secret    = '0;
    bus.init_ptA  = 2'd1;
    bus.round_in  = 2'd2;
    bus.init_ptB  = '0;
    tick(2);
    check("rst_lives", bus.lives_left, 0);
    check("rst_ptA", bus.pointsOfA, 0);
    check("rst_round", bus.round_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_guess", bus.guess, 0);
    check("rst_fb_valid", bus.fb_valid, 0);
    check("rst_round_done", bus.round_done, 0);
    check("rst_exact", bus.exact_cnt, 0);
    reset = 1'b1;
    tick(1);
    check("idle_load_lives", bus.lives_left, LIVES);
    check("idle_load_ptA", bus.pointsOfA, 1);
    check("idle_load_round", bus.round_out, 2);

    // Breaker A wins first try
    start_round(1'b0, code4(1, 2, 3, 4), 0, 0, 0);
    round_q.push_back('{1, 0, 1, 0});
    play_guess(1'b0, code4(1, 2, 3, 4), code4(1, 2, 3, 4), 0);
    wait_idle();
    check("rounds_done_1", rd_count, 1);

    // Mixed feedback then a win
    start_round(1'b0, code4(1, 1, 2, 3), 1, 0, 1);
    play_guess(1'b0, code4(1, 2, 1, 5), code4(1, 1, 2, 3), 0);
    round_q.push_back('{2, 0, 2, 0});
    play_guess(1'b0, code4(1, 1, 2, 3), code4(1, 1, 2, 3), 0);
    wait_idle();
    check("rounds_done_2", rd_count, 2);

    // Enter filtering: blank symbol, wrong player, simultaneous enters
    start_round(1'b0, code4(5, 1, 1, 2), 2, 0, 2);
    press(1'b1, 1'b0, 0);
    press(1'b0, 1'b1, 3);
    press(1'b1, 1'b1, 5);
    check("filter_guess", bus.guess, 12'o0005);
    round_q.push_back('{3, 0, 3, 0});
    play_guess(1'b0, code4(5, 1, 1, 2), code4(5, 1, 1, 2), 1);
    wait_idle();
    check("rounds_done_3", rd_count, 3);

    // Breaker B runs out of lives
    start_round(1'b1, code4(1, 2, 3, 4), 1, 2, 0);
    play_guess(1'b1, code4(4, 3, 2, 1), code4(1, 2, 3, 4), 0);
    play_guess(1'b1, code4(5, 5, 5, 5), code4(1, 2, 3, 4), 0);
    round_q.push_back('{2, 2, 1, 1});
    play_guess(1'b1, code4(1, 2, 4, 3), code4(1, 2, 3, 4), 0);
    wait_idle();
    check("rounds_done_4", rd_count, 4);

    // Point saturation and round wrap
    start_round(1'b0, code4(7, 6, 5, 4), 3, 1, 3);
    round_q.push_back('{3, 1, 0, 0});
    play_guess(1'b0, code4(7, 6, 5, 4), code4(7, 6, 5, 4), 0);
    wait_idle();
    check("rounds_done_5", rd_count, 5);

    // Reset mid-entry aborts the round
    start_round(1'b0, code4(1, 2, 3, 4), 2, 1, 1);
    press(1'b1, 1'b0, 2);
    press(1'b1, 1'b0, 3);
    check("pre_reset_guess", bus.guess, 12'o0023);
    #2 reset = 1'b0;
    #1;
    check("abort_guess", bus.guess, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_lives", bus.lives_left, 0);
    check("abort_ptA", bus.pointsOfA, 0);
    check("abort_round", bus.round_out, 0);
    check("abort_round_done", bus.round_done, 0);
    tick(3);
    reset = 1'b1;
    tick(HOLD * 3);
    check("abort_no_round_done", rd_count, 5);
    check("abort_reload_lives", bus.lives_left, LIVES);
    check("abort_idle", bus.busy, 0);

    check("score_q_drained", score_q.size(), 0);
    check("round_q_drained", round_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
